// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer arbiter: state encoding, default
// widths, the post-pattern guard time and the owner-index width helper.
package buzz_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } buzz_state_e;

  // Default configuration.
  localparam int BUZZ_N_REQ_DEF  = 4;
  localparam int BUZZ_CNT_W_DEF  = 8;
  localparam int BUZZ_BEEP_W_DEF = 3;
  localparam int BUZZ_GAP_MS_DEF = 20;

  // Width of an index into the requester vector; never less than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buzz_prio_enc.sv
// Fixed-priority encoder: index 0 wins. Produces the one-hot winner, its
// binary index and a valid flag for a pending-request vector.
module buzz_prio_enc
  import buzz_pkg::*;
#(
  parameter int N     = BUZZ_N_REQ_DEF,
  parameter int IDX_W = owner_w(N)
) (
  input  logic [N-1:0]     pend_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Isolate the lowest set bit (two's-complement trick).
  assign onehot_o = pend_i & (~pend_i + N'(1));
  assign valid_o  = |pend_i;

  // Convert the one-hot winner into a binary index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_o[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/buzz_arbiter.sv
// Buzzer arbiter: latches beep requests from several sources, grants them by
// fixed priority (index 0 highest) and plays the granted on/off pattern on
// o_buzzer, timed by the shared 1 kHz tick. After every pattern a silent
// guard gap is inserted before the next grant.
// Optional feature macro: BUZZ_PREEMPT_EN (a higher-priority pending request
// aborts the pattern in progress and starts immediately, skipping the gap).
module buzz_arbiter
  import buzz_pkg::*;
#(
  parameter int N_REQ  = BUZZ_N_REQ_DEF,
  parameter int CNT_W  = BUZZ_CNT_W_DEF,
  parameter int BEEP_W = BUZZ_BEEP_W_DEF,
  parameter int GAP_MS = BUZZ_GAP_MS_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pls_1k,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*BEEP_W-1:0] i_beeps,
  input  logic [N_REQ*CNT_W-1:0]  i_on_ms,
  input  logic [N_REQ*CNT_W-1:0]  i_off_ms,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_buzzer
);

  localparam int OWN_W = owner_w(N_REQ);
  // Last count value of the guard gap; a zero gap behaves as one tick.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_MS > 1) ? (GAP_MS - 1) : 0);

  // Per-source pattern fields, with zero durations promoted to one tick.
  logic [BEEP_W-1:0] beeps_a [N_REQ];
  logic [CNT_W-1:0]  on_a    [N_REQ];
  logic [CNT_W-1:0]  off_a   [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign beeps_a[gi] = i_beeps[gi*BEEP_W +: BEEP_W];
      assign on_a[gi]    = (i_on_ms[gi*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                               : i_on_ms[gi*CNT_W +: CNT_W];
      assign off_a[gi]   = (i_off_ms[gi*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                                : i_off_ms[gi*CNT_W +: CNT_W];
    end
  endgenerate

  // State and datapath registers.
  buzz_state_e       state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [BEEP_W-1:0] beeps_left_q, beeps_left_d;
  logic [CNT_W-1:0]  on_q, on_d;
  logic [CNT_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              done_q, done_d;
  logic              buzzer_q, buzzer_d;

  // Winner among pending requests.
  logic [N_REQ-1:0]  win_oh;
  logic [OWN_W-1:0]  win_idx;
  logic              win_valid;
  logic [BEEP_W-1:0] win_beeps;
  logic [CNT_W-1:0]  win_on;
  logic [CNT_W-1:0]  win_off;

  logic              start;
  logic              preempt;
  logic [N_REQ-1:0]  clr_mask;

  buzz_prio_enc #(
    .N     (N_REQ),
    .IDX_W (OWN_W)
  ) u_prio (
    .pend_i   (pending_q),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  assign win_beeps = beeps_a[win_idx];
  assign win_on    = on_a[win_idx];
  assign win_off   = off_a[win_idx];

`ifdef BUZZ_PREEMPT_EN
  // Owner of the pattern in progress, needed only to decide preemption.
  logic [OWN_W-1:0] owner_q, owner_d;

  // Abort when the best pending source outranks the current owner.
  assign preempt = win_valid && (win_idx < owner_q);

  // Owner register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q <= '0;
    end else begin
      owner_q <= owner_d;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  // Next-state, pattern sequencing and pending-latch update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beeps_left_d = beeps_left_q;
    on_d         = on_q;
    off_d        = off_q;
    grant_d      = '0;
    done_d       = 1'b0;
    buzzer_d     = buzzer_q;
    clr_mask     = '0;
    start        = 1'b0;
`ifdef BUZZ_PREEMPT_EN
    owner_d      = owner_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        start = win_valid;
      end

      ST_ON: begin
        if (preempt) begin
          start = 1'b1;
        end else if (i_pls_1k) begin
          if (cnt_q == on_q - CNT_W'(1)) begin
            cnt_d        = '0;
            beeps_left_d = beeps_left_q - BEEP_W'(1);
            buzzer_d     = 1'b0;
            if (beeps_left_q == BEEP_W'(1)) begin
              state_d = ST_GAP;
              done_d  = 1'b1;
            end else begin
              state_d = ST_OFF;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_OFF: begin
        if (preempt) begin
          start = 1'b1;
        end else if (i_pls_1k) begin
          if (cnt_q == off_q - CNT_W'(1)) begin
            cnt_d    = '0;
            state_d  = ST_ON;
            buzzer_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (i_pls_1k) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        buzzer_d = 1'b0;
      end
    endcase

    // Start a pattern for the winner: latch its fields and pulse its grant.
    // A zero beep count still grants but falls straight into the gap.
    if (start) begin
      grant_d      = win_oh;
      clr_mask     = win_oh;
      cnt_d        = '0;
      beeps_left_d = win_beeps;
      on_d         = win_on;
      off_d        = win_off;
`ifdef BUZZ_PREEMPT_EN
      owner_d      = win_idx;
`endif
      if (win_beeps == '0) begin
        state_d  = ST_GAP;
        buzzer_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        state_d  = ST_ON;
        buzzer_d = 1'b1;
      end
    end

    // A new request in the same cycle as its grant wins over the clear.
    pending_d = (pending_q & ~clr_mask) | i_req;
  end

  // State and datapath registers; reset silences the buzzer at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      beeps_left_q <= '0;
      on_q         <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= 1'b0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      beeps_left_q <= beeps_left_d;
      on_q         <= on_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      buzzer_q     <= buzzer_d;
    end
  end

  assign o_grant  = grant_q;
  assign o_done   = done_q;
  assign o_buzzer = buzzer_q;
  assign o_busy   = (state_q != ST_IDLE);

endmodule
